// File: rtl/spi_master_pingpong_if.sv
// Frame-request and ping-pong RAM port bundle for spi_master_pingpong.
// The master modport is the SPI master's side; the slave modport is the system/RAM side.
interface spi_master_pingpong_if #(
  parameter int ADDR_W = 7
);
  logic              start;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              ready_tx;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              finish_tx;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_en;
  logic              finish_rx;

  modport master (
    input  start, len, ready_tx, rd_data,
    output busy, done, rd_addr, finish_tx, wr_addr, wr_data, wr_en, finish_rx
  );

  modport slave (
    output start, len, ready_tx, rd_data,
    input  busy, done, rd_addr, finish_tx, wr_addr, wr_data, wr_en, finish_rx
  );
endinterface

// File: rtl/spi_master_pingpong.sv
// SPI mode-0 master, MSB first: one ssel window per frame of len bytes,
// TX bytes from a ping-pong read port, RX bytes to a ping-pong write port.
module spi_master_pingpong #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_master_pingpong_if.master bus,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  ssel
);
  localparam int DIV_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, XFER, HOLD, GAP} state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [2:0]       bit_cnt;
  logic [ADDR_W:0]  len_q;
  logic [ADDR_W:0]  byte_cnt;
  logic             tx_valid;
  logic [7:0]       tx_sh;
  logic [7:0]       rx_sh;
  logic [1:0]       miso_s;
  logic             tick;
  logic             last_byte;

  assign tick      = (div == DIV_W'(CLK_DIV - 1));
  assign last_byte = (byte_cnt == len_q - 1'b1);
  assign mosi      = tx_sh[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      div           <= '0;
      bit_cnt       <= '0;
      len_q         <= '0;
      byte_cnt      <= '0;
      tx_valid      <= 1'b0;
      tx_sh         <= '0;
      rx_sh         <= '0;
      miso_s        <= '0;
      sck           <= 1'b0;
      ssel          <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.finish_tx <= 1'b0;
      bus.finish_rx <= 1'b0;
      bus.rd_addr   <= '0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.wr_en     <= 1'b0;
    end else begin
      miso_s        <= {miso_s[0], miso};
      bus.done      <= 1'b0;
      bus.finish_tx <= 1'b0;
      bus.finish_rx <= 1'b0;
      bus.wr_en     <= 1'b0;
      // Write address advances the cycle after each strobe so it names the byte just written.
      if (bus.wr_en) bus.wr_addr <= bus.wr_addr + 1'b1;

      case (state)
        IDLE: begin
          if (bus.start && bus.len != '0) begin
            len_q       <= bus.len;
            tx_valid    <= bus.ready_tx;
            bus.rd_addr <= '0;
            bus.wr_addr <= '0;
            byte_cnt    <= '0;
            bit_cnt     <= '0;
            bus.busy    <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          tx_sh       <= tx_valid ? bus.rd_data : '0;
          bus.rd_addr <= bus.rd_addr + 1'b1;
          ssel        <= 1'b0;
          div         <= '0;
          state       <= XFER;
        end
        XFER: begin
          div <= tick ? '0 : div + 1'b1;
          if (tick) begin
            sck <= ~sck;
            if (!sck) begin
              rx_sh <= {rx_sh[6:0], miso_s[1]};
              if (bit_cnt == 3'd7) begin
                bus.wr_en   <= 1'b1;
                bus.wr_data <= {rx_sh[6:0], miso_s[1]};
              end
            end else if (bit_cnt != 3'd7) begin
              tx_sh   <= {tx_sh[6:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              bit_cnt <= '0;
              if (last_byte) begin
                state <= HOLD;
              end else begin
                // Next byte was prefetched a full byte-time ago, so rd_data is settled here.
                tx_sh       <= tx_valid ? bus.rd_data : '0;
                bus.rd_addr <= bus.rd_addr + 1'b1;
                byte_cnt    <= byte_cnt + 1'b1;
              end
            end
          end
        end
        HOLD: begin
          div <= tick ? '0 : div + 1'b1;
          if (tick) begin
            ssel          <= 1'b1;
            tx_sh         <= '0;
            bus.done      <= 1'b1;
            bus.finish_rx <= 1'b1;
            bus.finish_tx <= tx_valid;
            state         <= GAP;
          end
        end
        GAP: begin
          div <= tick ? '0 : div + 1'b1;
          if (tick) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_pingpong.sv
// Randomised scoreboard bench for spi_master_pingpong with a behavioural SPI slave,
// TX RAM model and decoupled monitor.
module tb_spi_master_pingpong;
  localparam int CD = 4;
  localparam int AW = 7;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  typedef struct {
    logic fin_tx;
    int   low;
    int   len;
  } fin_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sck, mosi, ssel;
  logic miso = 1'b0;

  spi_master_pingpong_if #(.ADDR_W(AW)) bus ();

  spi_master_pingpong #(.CLK_DIV(CD), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .sck   (sck),
    .mosi  (mosi),
    .miso  (miso),
    .ssel  (ssel)
  );

  always #5 clk = ~clk;

  logic [7:0] tx_mem   [128];
  logic [7:0] slave_ret[128];

  always @(posedge clk) bus.rd_data <= tx_mem[bus.rd_addr];

  int nerr = 0;
  int nchk = 0;
  int done_cnt = 0;

  wr_t        exp_wr[$];
  logic [7:0] exp_mosi[$];
  fin_t       exp_fin[$];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Behavioural SPI slave: drives miso, captures mosi, measures ssel timing.
  logic [7:0] mcap[$];
  int low_cnt = 0, high_cnt = 0, last_gap = 0;
  int bad_period = 0, rises = 0, since_rise = 0;
  int sidx = 0, sbit = 0, mcnt = 0;
  logic [7:0] sbyte = '0, mshift = '0;
  logic prev_ssel = 1'b1, prev_sck = 1'b0;

  always @(negedge clk) begin
    if (!ssel && prev_ssel) begin
      last_gap   = high_cnt;
      low_cnt    = 1;
      mcap.delete();
      mcnt       = 0;
      sidx       = 0;
      sbit       = 0;
      sbyte      = slave_ret[0];
      miso       = sbyte[7];
      bad_period = 0;
      rises      = 0;
      since_rise = 0;
    end else if (!ssel) begin
      low_cnt++;
      since_rise++;
      if (sck && !prev_sck) begin
        mshift = {mshift[6:0], mosi};
        mcnt++;
        if (mcnt == 8) begin
          mcap.push_back(mshift);
          mcnt = 0;
        end
        if (rises > 0 && since_rise != 2 * CD) bad_period++;
        rises++;
        since_rise = 0;
      end
      if (!sck && prev_sck) begin
        sbit++;
        if (sbit == 8) begin
          sbit = 0;
          sidx++;
          sbyte = (sidx < 128) ? slave_ret[sidx] : 8'h00;
        end else begin
          sbyte = {sbyte[6:0], 1'b0};
        end
        miso = sbyte[7];
      end
    end
    if (ssel) high_cnt = prev_ssel ? high_cnt + 1 : 1;
    prev_ssel = ssel;
    prev_sck  = sck;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a write or a frame end.
  always @(negedge clk) begin
    if (rst_n && bus.wr_en) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_write", 32'(bus.wr_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        chk("wr_data", 32'(bus.wr_data), 32'(e.data));
      end
    end
    if (rst_n && (bus.finish_rx || bus.finish_tx) && !bus.done)
      chk("finish_without_done", 32'(bus.done), 32'd1);
    if (rst_n && bus.done) begin
      done_cnt++;
      if (exp_fin.size() == 0) begin
        chk("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        fin_t f;
        f = exp_fin.pop_front();
        chk("finish_tx", 32'(bus.finish_tx), 32'(f.fin_tx));
        chk("finish_rx", 32'(bus.finish_rx), 32'd1);
        chk("ssel_low_cycles", 32'(low_cnt), 32'(f.low));
        chk("sck_period_errors", 32'(bad_period), 32'd0);
        chk("writes_outstanding", 32'(exp_wr.size()), 32'd0);
        chk("mosi_byte_count", 32'(mcap.size()), 32'(f.len));
        for (int i = 0; i < f.len; i++) begin
          logic [7:0] e, g;
          e = (exp_mosi.size() != 0) ? exp_mosi.pop_front() : 8'hxx;
          g = (i < mcap.size()) ? mcap[i] : 8'hxx;
          chk("mosi_byte", 32'(g), 32'(e));
        end
      end
    end
  end

  // Reference: master sends RAM bytes (or zeros without ready_tx), slave bytes land at 0..len-1.
  task automatic prep(input bit ramp);
    for (int i = 0; i < 128; i++) begin
      tx_mem[i]    = ramp ? 8'(i) : 8'($urandom);
      slave_ret[i] = ramp ? ~8'(i) : 8'($urandom);
    end
  endtask

  task automatic start_frame(input int L, input bit r);
    fin_t f;
    for (int i = 0; i < L; i++) begin
      exp_wr.push_back('{addr: AW'(i), data: slave_ret[i]});
      exp_mosi.push_back(r ? tx_mem[i] : 8'h00);
    end
    f.fin_tx = r;
    f.low    = (16 * L + 1) * CD;
    f.len    = L;
    exp_fin.push_back(f);
    bus.start    = 1'b1;
    bus.len      = 8'(L);
    bus.ready_tx = r;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.ready_tx = 1'($urandom);
  endtask

  task automatic wait_done(input int L);
    int t = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && t < (16 * L + 8) * CD + 50) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == d0) begin
      chk("done_timeout", 32'(t), 32'd0);
      exp_wr.delete();
      exp_mosi.delete();
      exp_fin.delete();
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy) chk("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int bad, d0, t;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.ready_tx = 1'b0;
    prep(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_ssel", 32'(ssel), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pulses", 32'({bus.done, bus.finish_tx, bus.finish_rx, bus.wr_en}), 32'd0);
    chk("rst_addrs", 32'({bus.rd_addr, bus.wr_addr, bus.wr_data}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte with known data in both directions.
    prep(1'b0);
    tx_mem[0]    = 8'hA5;
    slave_ret[0] = 8'h3C;
    start_frame(1, 1'b1);
    wait_done(1);
    wait_idle();

    // TX buffer not ready: zeros out, RX still written.
    prep(1'b0);
    start_frame(3, 1'b0);
    wait_done(3);
    wait_idle();

    // Full-size frame with ramp data and an inverting slave.
    prep(1'b1);
    start_frame(128, 1'b1);
    wait_done(128);
    wait_idle();

    // len=0 request ignored.
    bus.start = 1'b1;
    bus.len   = '0;
    @(negedge clk);
    bus.start = 1'b0;
    bad = 0;
    repeat (10) begin
      if (bus.busy || !ssel) bad++;
      @(negedge clk);
    end
    chk("len0_ignored", 32'(bad), 32'd0);

    // start mid-frame ignored: exactly one done.
    prep(1'b0);
    d0 = done_cnt;
    start_frame(2, 1'b1);
    repeat (40) @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(2);
    wait_idle();
    repeat (30) @(negedge clk);
    chk("single_done", 32'(done_cnt - d0), 32'd1);

    // Random frames.
    for (int k = 0; k < 4; k++) begin
      int L;
      bit r;
      prep(1'b0);
      L = $urandom_range(1, 12);
      r = 1'($urandom_range(0, 1));
      start_frame(L, r);
      wait_done(L);
      wait_idle();
    end

    // Reset during byte index 2 of a len=4 frame.
    prep(1'b0);
    start_frame(4, 1'b1);
    t = 0;
    while (ssel && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat ((2 * 16 + 4) * CD) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ssel", 32'(ssel), 32'd1);
    chk("abort_sck", 32'(sck), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    exp_wr.delete();
    exp_mosi.delete();
    exp_fin.delete();
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.finish_tx || bus.finish_rx || !ssel) bad++;
    end
    chk("abort_no_pulses", 32'(bad), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    prep(1'b0);
    start_frame(3, 1'b1);
    wait_done(3);

    // Back-to-back: start on the first cycle busy is low.
    wait_idle();
    prep(1'b0);
    start_frame(2, 1'b1);
    chk("b2b_accept", 32'(bus.busy), 32'd1);
    t = 0;
    while (ssel && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("b2b_ssel_gap_min", 32'(last_gap >= CD), 32'd1);
    wait_done(2);
    wait_idle();
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
